// File: rtl/pragmatic_mac_scheduler_if.sv
// Weight handshake and MAC control bundle for the Pragmatic MAC scheduler.
// master: weight source (drives the vector handshake, observes MAC controls).
// slave : the scheduler itself.
interface pragmatic_mac_scheduler_if #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LENGTH = 16
);
    logic                                   w_valid;
    logic                                   w_ready;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  w_in;
    logic                                   w_acc_first;
    logic                                   mac_en;
    logic                                   mac_load_accum;
    logic [VEC_LENGTH-1:0][1:0]             shift_1st_sel;
    logic [VEC_LENGTH-1:0]                  shift_1st_en;
    logic [VEC_LENGTH-1:0]                  is_neg;
    logic [$clog2(DATA_WIDTH)-1:0]          shift_2nd_sel;
    logic                                   shift_2nd_en;
    logic                                   busy;
    logic                                   done;

    modport master (
        output w_valid, w_in, w_acc_first,
        input  w_ready, mac_en, mac_load_accum, shift_1st_sel, shift_1st_en,
               is_neg, shift_2nd_sel, shift_2nd_en, busy, done
    );

    modport slave (
        input  w_valid, w_in, w_acc_first,
        output w_ready, mac_en, mac_load_accum, shift_1st_sel, shift_1st_en,
               is_neg, shift_2nd_sel, shift_2nd_en, busy, done
    );
endinterface

// File: rtl/pragmatic_mac_scheduler.sv
// Sequencer for the Pragmatic bit-serial MAC: splits each signed weight into
// its essential (set magnitude) bits and issues one per lane per cycle as a
// common base shift plus a small per-lane offset. All outputs are registered.
// Optional macro PRAGMATIC_SCHED_STATS_EN adds issue-cycle statistics ports.
module pragmatic_mac_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LENGTH = 16,
    parameter int OFS_RANGE  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    pragmatic_mac_scheduler_if.slave      bus
`ifdef PRAGMATIC_SCHED_STATS_EN
    ,
    output logic [3:0]                    last_issue_cycles,
    output logic [31:0]                   total_issue_cycles
`endif
);
    localparam int LW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   rem [VEC_LENGTH];
    logic [VEC_LENGTH-1:0]   sgn;
    logic                    ld_pend;
`ifdef PRAGMATIC_SCHED_STATS_EN
    logic [3:0]              issue_cnt;
`endif

    logic [DATA_WIDTH-1:0]   rem_after [VEC_LENGTH];
    logic [DATA_WIDTH-1:0]   rem_src   [VEC_LENGTH];
    logic [VEC_LENGTH-1:0]   sgn_src;
    logic [LW-1:0]           lo        [VEC_LENGTH];
    logic [LW-1:0]           diff      [VEC_LENGTH];
    logic [LW-1:0]           base_d;
    logic                    any_d;
    logic                    all_zero_after;
    logic [VEC_LENGTH-1:0]   fire_d;
    logic [VEC_LENGTH-1:0]   neg_d;
    logic [VEC_LENGTH-1:0][1:0] sel_d;

    // |w| over DATA_WIDTH bits; the most negative weight maps to 1 << (DATA_WIDTH-1).
    function automatic logic [DATA_WIDTH-1:0] mag(input logic signed [DATA_WIDTH-1:0] w);
        logic signed [DATA_WIDTH-1:0] n;
        n = -w;
        return w[DATA_WIDTH-1] ? $unsigned(n) : $unsigned(w);
    endfunction

    // Index of the lowest set bit (0 for a zero input).
    function automatic logic [LW-1:0] low_idx(input logic [DATA_WIDTH-1:0] v);
        logic [LW-1:0] r;
        r = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (v[i]) r = LW'(i);
        end
        return r;
    endfunction

    // Saturating accumulate of a per-vector cycle count.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [3:0] b);
        logic [32:0] s;
        s = {1'b0, a} + 33'(b);
        return s[32] ? '1 : s[31:0];
    endfunction

    // Decode the issue slot for the coming cycle from the residuals it will see.
    always_comb begin
        base_d         = '1;
        any_d          = 1'b0;
        all_zero_after = 1'b1;
        fire_d         = '0;
        neg_d          = '0;
        sel_d          = '0;
        for (int j = 0; j < VEC_LENGTH; j++) begin
            // Lanes fired this cycle lose their lowest set bit at the edge.
            rem_after[j] = bus.shift_1st_en[j] ? (rem[j] & (rem[j] - DATA_WIDTH'(1))) : rem[j];
            if (rem_after[j] != '0) all_zero_after = 1'b0;
            if (state == IDLE) begin
                rem_src[j] = mag($signed(bus.w_in[j]));
                sgn_src[j] = bus.w_in[j][DATA_WIDTH-1];
            end else begin
                rem_src[j] = rem_after[j];
                sgn_src[j] = sgn[j];
            end
            lo[j] = low_idx(rem_src[j]);
            if (rem_src[j] != '0) begin
                any_d = 1'b1;
                if (lo[j] < base_d) base_d = lo[j];
            end
        end
        if (!any_d) base_d = '0;
        for (int j = 0; j < VEC_LENGTH; j++) begin
            diff[j] = lo[j] - base_d;
            if (rem_src[j] != '0 && int'(diff[j]) < OFS_RANGE) begin
                fire_d[j] = 1'b1;
                sel_d[j]  = diff[j][1:0];
                neg_d[j]  = sgn_src[j];
            end
        end
    end

    // Control FSM with registered MAC controls.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state              <= IDLE;
            ld_pend            <= 1'b0;
            sgn                <= '0;
            for (int j = 0; j < VEC_LENGTH; j++) rem[j] <= '0;
            bus.w_ready        <= 1'b1;
            bus.mac_en         <= 1'b0;
            bus.mac_load_accum <= 1'b0;
            bus.shift_1st_en   <= '0;
            bus.shift_1st_sel  <= '0;
            bus.is_neg         <= '0;
            bus.shift_2nd_sel  <= '0;
            bus.shift_2nd_en   <= 1'b0;
            bus.busy           <= 1'b0;
            bus.done           <= 1'b0;
`ifdef PRAGMATIC_SCHED_STATS_EN
            issue_cnt          <= '0;
            last_issue_cycles  <= '0;
            total_issue_cycles <= '0;
`endif
        end else begin
            bus.done           <= 1'b0;
            bus.mac_load_accum <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.w_valid) begin
                        state             <= ISSUE;
                        for (int j = 0; j < VEC_LENGTH; j++) rem[j] <= rem_src[j];
                        sgn               <= sgn_src;
                        ld_pend           <= bus.w_acc_first;
                        bus.w_ready       <= 1'b0;
                        bus.busy          <= 1'b1;
                        bus.mac_en        <= 1'b1;
                        bus.shift_1st_en  <= fire_d;
                        bus.shift_1st_sel <= sel_d;
                        bus.is_neg        <= neg_d;
                        bus.shift_2nd_sel <= base_d;
                        bus.shift_2nd_en  <= any_d;
`ifdef PRAGMATIC_SCHED_STATS_EN
                        issue_cnt         <= '0;
`endif
                    end
                end
                ISSUE: begin
                    for (int j = 0; j < VEC_LENGTH; j++) rem[j] <= rem_src[j];
                    // The first psum lands in the MAC psum register one cycle later.
                    if (ld_pend) begin
                        bus.mac_load_accum <= 1'b1;
                        ld_pend            <= 1'b0;
                    end
`ifdef PRAGMATIC_SCHED_STATS_EN
                    issue_cnt <= issue_cnt + 4'd1;
`endif
                    if (all_zero_after) begin
                        state             <= DRAIN;
                        bus.shift_1st_en  <= '0;
                        bus.shift_1st_sel <= '0;
                        bus.is_neg        <= '0;
                        bus.shift_2nd_sel <= '0;
                        bus.shift_2nd_en  <= 1'b0;
                    end else begin
                        bus.shift_1st_en  <= fire_d;
                        bus.shift_1st_sel <= sel_d;
                        bus.is_neg        <= neg_d;
                        bus.shift_2nd_sel <= base_d;
                        bus.shift_2nd_en  <= any_d;
                    end
                end
                DRAIN: begin
                    state       <= IDLE;
                    bus.mac_en  <= 1'b0;
                    bus.busy    <= 1'b0;
                    bus.w_ready <= 1'b1;
                    bus.done    <= 1'b1;
`ifdef PRAGMATIC_SCHED_STATS_EN
                    last_issue_cycles  <= issue_cnt;
                    total_issue_cycles <= sat_add32(total_issue_cycles, issue_cnt);
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pragmatic_mac_scheduler.sv
// Self-checking bench for pragmatic_mac_scheduler: directed and random weight
// vectors compared cycle by cycle against an essential-bit reference model.
module tb_pragmatic_mac_scheduler;
    localparam int DW = 8;
    localparam int VL = 16;

    typedef logic [DW-1:0] wvec_t [VL];

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pragmatic_mac_scheduler_if #(.DATA_WIDTH(DW), .VEC_LENGTH(VL)) bus ();

`ifdef PRAGMATIC_SCHED_STATS_EN
    logic [3:0]  last_issue_cycles;
    logic [31:0] total_issue_cycles;
    longint unsigned exp_total = 0;
`endif

    pragmatic_mac_scheduler #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .OFS_RANGE(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef PRAGMATIC_SCHED_STATS_EN
        ,
        .last_issue_cycles  (last_issue_cycles),
        .total_issue_cycles (total_issue_cycles)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " w_ready"}, 64'(bus.w_ready), 64'd1);
        check({tag, " busy"}, 64'(bus.busy), 64'd0);
        check({tag, " mac_en"}, 64'(bus.mac_en), 64'd0);
        check({tag, " load"}, 64'(bus.mac_load_accum), 64'd0);
        check({tag, " en1"}, 64'(bus.shift_1st_en), 64'd0);
        check({tag, " sel1"}, 64'(bus.shift_1st_sel), 64'd0);
        check({tag, " neg"}, 64'(bus.is_neg), 64'd0);
        check({tag, " sel2"}, 64'(bus.shift_2nd_sel), 64'd0);
        check({tag, " en2"}, 64'(bus.shift_2nd_en), 64'd0);
        check({tag, " done"}, 64'(bus.done), 64'd0);
    endtask

    // Hand one vector over, then follow it through ISSUE/DRAIN to its done cycle.
    // Returns with the bench sitting in the done cycle (IDLE, ready for the next).
    task automatic run_vec(input wvec_t w, input logic first, input logic hold,
                           input string tag, output int n);
        logic [DW-1:0] rem [VL];
        logic          sg  [VL];
        int            lo  [VL];
        int            base;
        int            v;
        logic          any;
        logic          remaining;
        logic [VL-1:0]   een, eneg;
        logic [2*VL-1:0] esel;

        check({tag, " w_ready idle"}, 64'(bus.w_ready), 64'd1);
        bus.w_valid = 1'b1;
        for (int j = 0; j < VL; j++) bus.w_in[j] = w[j];
        bus.w_acc_first = first;
        tick();
        if (!hold) begin
            bus.w_valid = 1'b0;
            for (int j = 0; j < VL; j++) bus.w_in[j] = DW'($urandom);
            bus.w_acc_first = 1'($urandom);
        end

        for (int j = 0; j < VL; j++) begin
            v = int'($signed(w[j]));
            rem[j] = DW'(v < 0 ? -v : v);
            sg[j]  = (v < 0);
        end

        n = 0;
        do begin
            any = 1'b0;
            base = DW;
            for (int j = 0; j < VL; j++) begin
                lo[j] = 0;
                if (rem[j] != 0) begin
                    while (((rem[j] >> lo[j]) & 8'd1) == 0) lo[j]++;
                    any = 1'b1;
                    if (lo[j] < base) base = lo[j];
                end
            end
            if (!any) base = 0;
            een = '0; eneg = '0; esel = '0;
            for (int j = 0; j < VL; j++) begin
                if (rem[j] != 0 && lo[j] - base < 4) begin
                    een[j] = 1'b1;
                    esel[2*j +: 2] = 2'(lo[j] - base);
                    eneg[j] = sg[j];
                    rem[j] = rem[j] & ~(8'd1 << lo[j]);
                end
            end
            n++;
            check({tag, " issue mac_en"}, 64'(bus.mac_en), 64'd1);
            check({tag, " issue w_ready"}, 64'(bus.w_ready), 64'd0);
            check({tag, " issue busy"}, 64'(bus.busy), 64'd1);
            check({tag, " issue done"}, 64'(bus.done), 64'd0);
            check({tag, " issue en1"}, 64'(bus.shift_1st_en), 64'(een));
            check({tag, " issue sel1"}, 64'(bus.shift_1st_sel), 64'(esel));
            check({tag, " issue neg"}, 64'(bus.is_neg), 64'(eneg));
            check({tag, " issue sel2"}, 64'(bus.shift_2nd_sel), 64'(base));
            check({tag, " issue en2"}, 64'(bus.shift_2nd_en), 64'(any));
            check({tag, " issue load"}, 64'(bus.mac_load_accum), 64'(first && n == 2));
            tick();
            remaining = 1'b0;
            for (int j = 0; j < VL; j++) if (rem[j] != 0) remaining = 1'b1;
        end while (remaining && n < 16);

        check({tag, " drain mac_en"}, 64'(bus.mac_en), 64'd1);
        check({tag, " drain en1"}, 64'(bus.shift_1st_en), 64'd0);
        check({tag, " drain en2"}, 64'(bus.shift_2nd_en), 64'd0);
        check({tag, " drain sel2"}, 64'(bus.shift_2nd_sel), 64'd0);
        check({tag, " drain w_ready"}, 64'(bus.w_ready), 64'd0);
        check({tag, " drain done"}, 64'(bus.done), 64'd0);
        check({tag, " drain load"}, 64'(bus.mac_load_accum), 64'(first && n == 1));
        tick();
        check({tag, " done"}, 64'(bus.done), 64'd1);
        check({tag, " done w_ready"}, 64'(bus.w_ready), 64'd1);
        check({tag, " done busy"}, 64'(bus.busy), 64'd0);
        check({tag, " done mac_en"}, 64'(bus.mac_en), 64'd0);
        check({tag, " done load"}, 64'(bus.mac_load_accum), 64'd0);
`ifdef PRAGMATIC_SCHED_STATS_EN
        exp_total += longint'(n);
        check({tag, " last N"}, 64'(last_issue_cycles), 64'(n));
        check({tag, " total N"}, 64'(total_issue_cycles), 64'(exp_total));
`endif
    endtask

    initial begin
        wvec_t w;
        int    n;

        bus.w_valid = 1'b0;
        bus.w_acc_first = 1'b0;
        for (int j = 0; j < VL; j++) bus.w_in[j] = '0;

        // Reset state
        reset = 1'b0;
        tick();
        tick();
        check_reset_vals("reset");
`ifdef PRAGMATIC_SCHED_STATS_EN
        check("reset total", 64'(total_issue_cycles), 64'd0);
`endif
        reset = 1'b1;
        tick();
        check_reset_vals("idle");

        // All lanes 0x01, new accumulation
        for (int j = 0; j < VL; j++) w[j] = 8'h01;
        run_vec(w, 1'b1, 1'b0, "ones", n);
        check("ones N", 64'(n), 64'd1);
        tick();
        check("ones done pulse", 64'(bus.done), 64'd0);

        // Lane0 = 3, lane1 = 0x10: offset window forces a second cycle
        for (int j = 0; j < VL; j++) w[j] = 8'h00;
        w[0] = 8'h03;
        w[1] = 8'h10;
        run_vec(w, 1'b0, 1'b0, "win", n);

        // Most negative weight
        for (int j = 0; j < VL; j++) w[j] = 8'h00;
        w[0] = 8'h80;
        run_vec(w, 1'b0, 1'b0, "m128", n);

        // -127: seven essential bits, load in the 2nd ISSUE cycle
        w[0] = 8'h81;
        run_vec(w, 1'b1, 1'b0, "m127", n);

        // All-zero vector with w_valid held high throughout
        for (int j = 0; j < VL; j++) w[j] = 8'h00;
        run_vec(w, 1'b1, 1'b1, "zero", n);

        // Random vectors; the first is accepted from the done cycle above
        for (int k = 0; k < 30; k++) begin
            for (int j = 0; j < VL; j++)
                w[j] = ($urandom_range(0, 2) == 0) ? 8'h00 : DW'($urandom);
            if (k == 7) w[3] = 8'h80;
            run_vec(w, 1'($urandom), 1'b0, "rand", n);
            if ($urandom_range(0, 1) == 1) begin
                tick();
                check("rand gap done", 64'(bus.done), 64'd0);
            end
        end

        // Reset during the 3rd ISSUE cycle of -127
        tick();
        for (int j = 0; j < VL; j++) bus.w_in[j] = '0;
        bus.w_in[0] = 8'h81;
        bus.w_acc_first = 1'b1;
        bus.w_valid = 1'b1;
        tick();
        bus.w_valid = 1'b0;
        check("mid issue1 sel2", 64'(bus.shift_2nd_sel), 64'd0);
        tick();
        check("mid issue2 load", 64'(bus.mac_load_accum), 64'd1);
        tick();
        check("mid issue3 sel2", 64'(bus.shift_2nd_sel), 64'd2);
        check("mid issue3 neg", 64'(bus.is_neg), 64'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_reset_vals("midrst");
`ifdef PRAGMATIC_SCHED_STATS_EN
        exp_total = 0;
        check("midrst total", 64'(total_issue_cycles), 64'd0);
        check("midrst last", 64'(last_issue_cycles), 64'd0);
`endif
        tick();
        check("midrst no done", 64'(bus.done), 64'd0);
        check("midrst mac_en", 64'(bus.mac_en), 64'd0);

        // Recovery after the aborted vector
        for (int j = 0; j < VL; j++) w[j] = DW'(j * 37 + 5);
        run_vec(w, 1'b1, 1'b0, "post", n);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
